// File: rtl/miriscv_alu_pkg.sv
// Shared definitions for the miriscv integer ALU: operator width, opcode
// encodings and opcode classification helpers.
package miriscv_alu_pkg;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 7'b0010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA = 7'b0100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 7'b0100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS = 7'b0000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 7'b0000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES = 7'b0001010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 7'b0001011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 7'b0001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE  = 7'b0001101;

  function automatic logic is_comparison(logic [ALU_OP_WIDTH-1:0] op);
    return op inside {ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE};
  endfunction

  function automatic logic is_valid_op(logic [ALU_OP_WIDTH-1:0] op);
    return is_comparison(op) ||
           (op inside {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
                       ALU_SRA, ALU_SRL, ALU_SLL});
  endfunction

endpackage

// File: rtl/miriscv_alu_cmp.sv
// Combinational comparator for the compare opcodes; zero latency, no backpressure.
// Flag is 0 for any opcode that is not a comparison.
module miriscv_alu_cmp
  import miriscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         operand_a,
  input  logic [XLEN-1:0]         operand_b,
  input  logic [ALU_OP_WIDTH-1:0] operator,
  output logic                    cmp_flag
);

  logic lt_s;
  logic lt_u;
  logic eq;

  assign lt_s = $signed(operand_a) < $signed(operand_b);
  assign lt_u = operand_a < operand_b;
  assign eq   = operand_a == operand_b;

  always_comb begin
    cmp_flag = 1'b0;
    case (operator)
      ALU_LTS: cmp_flag = lt_s;
      ALU_LTU: cmp_flag = lt_u;
      ALU_GES: cmp_flag = ~lt_s;
      ALU_GEU: cmp_flag = ~lt_u;
      ALU_EQ:  cmp_flag = eq;
      ALU_NE:  cmp_flag = ~eq;
      default: cmp_flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/miriscv_alu.sv
// RV32I execute-stage ALU: 14 ops, registered outputs, 1-cycle latency, no stall/backpressure.
// MIRISCV_ALU_ILLEGAL_OP_EN adds a registered illegal_op_o flag for unknown opcodes.
module miriscv_alu
  import miriscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [XLEN-1:0]         operand_a_i,
  input  logic [XLEN-1:0]         operand_b_i,
  output logic [XLEN-1:0]         result_o,
  output logic                    comparison_result_o
`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
  ,
  output logic                    illegal_op_o
`endif
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] result_d;
  logic            cmp_flag;

  assign shamt = operand_b_i[SHW-1:0];

  miriscv_alu_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .operand_a (operand_a_i),
    .operand_b (operand_b_i),
    .operator  (operator_i),
    .cmp_flag  (cmp_flag)
  );

  always_comb begin
    result_d = '0;
    case (operator_i)
      ALU_ADD: result_d = operand_a_i + operand_b_i;
      ALU_SUB: result_d = operand_a_i - operand_b_i;
      ALU_XOR: result_d = operand_a_i ^ operand_b_i;
      ALU_OR:  result_d = operand_a_i | operand_b_i;
      ALU_AND: result_d = operand_a_i & operand_b_i;
      ALU_SRA: result_d = $unsigned($signed(operand_a_i) >>> shamt);
      ALU_SRL: result_d = operand_a_i >> shamt;
      ALU_SLL: result_d = operand_a_i << shamt;
      default: begin
        // Unknown opcodes fall through with result_d = 0.
        if (is_comparison(operator_i)) begin
          result_d = {{(XLEN-1){1'b0}}, cmp_flag};
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o            <= '0;
      comparison_result_o <= 1'b0;
    end else begin
      result_o            <= result_d;
      comparison_result_o <= cmp_flag;
    end
  end

`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_op_o <= 1'b0;
    end else begin
      illegal_op_o <= ~is_valid_op(operator_i);
    end
  end
`endif

endmodule

// File: tb/tb_miriscv_alu.sv
// Directed self-checking bench for miriscv_alu; expected values are hand-computed constants.
module tb_miriscv_alu;

  localparam logic [6:0] OP_ADD = 7'h18;
  localparam logic [6:0] OP_SUB = 7'h19;
  localparam logic [6:0] OP_XOR = 7'h2F;
  localparam logic [6:0] OP_OR  = 7'h2E;
  localparam logic [6:0] OP_AND = 7'h15;
  localparam logic [6:0] OP_SRA = 7'h24;
  localparam logic [6:0] OP_SRL = 7'h25;
  localparam logic [6:0] OP_SLL = 7'h27;
  localparam logic [6:0] OP_LTS = 7'h00;
  localparam logic [6:0] OP_LTU = 7'h01;
  localparam logic [6:0] OP_GES = 7'h0A;
  localparam logic [6:0] OP_GEU = 7'h0B;
  localparam logic [6:0] OP_EQ  = 7'h0C;
  localparam logic [6:0] OP_NE  = 7'h0D;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        cmp;
`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  miriscv_alu dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .operator_i          (op),
    .operand_a_i         (a),
    .operand_b_i         (b),
    .result_o            (result),
    .comparison_result_o (cmp)
`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
    ,
    .illegal_op_o        (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one operation, then samples 1 time unit after the capturing edge.
  task automatic drive(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(OP_ADD, 32'd5, 32'd7);
      n_checks++;
      if (result !== 32'd0 || cmp !== 1'b0)
        $display("FAIL reset_hold[%0d]: result=%h cmp=%b expected result=00000000 cmp=0", i, result, cmp);
      else n_pass++;
    end
    rst = 1'b0;
    drive(OP_ADD, 32'd5, 32'd7);
    n_checks++;
    if (result !== 32'd12)
      $display("FAIL reset_release: result=%h expected 0000000c", result);
    else n_pass++;
  endtask

  task automatic test_arith;
    logic [6:0]  ops [6] = '{OP_ADD, OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND};
    logic [31:0] av  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv  [6] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] exp [6] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], av[i], bv[i]);
      n_checks++;
      if (result !== exp[i] || cmp !== 1'b0)
        $display("FAIL arith[%0d] op=%h: result=%h cmp=%b expected result=%h cmp=0", i, ops[i], result, cmp, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_shift;
    logic [6:0]  ops [7] = '{OP_SRA, OP_SRA, OP_SRL, OP_SRL, OP_SLL, OP_SLL, OP_SLL};
    logic [31:0] av  [7] = '{32'hFFFFFFFF, 32'h80000000, 32'h40000001, 32'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] bv  [7] = '{32'hFFFFFFFF, 32'd4, 32'd1, 32'd1, 32'd1, 32'd31, 32'h20};
    logic [31:0] exp [7] = '{32'hFFFFFFFF, 32'hF8000000, 32'h20000000, 32'd8, 32'hFFFFFFFE, 32'h80000000, 32'h12345678};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], av[i], bv[i]);
      n_checks++;
      if (result !== exp[i] || cmp !== 1'b0)
        $display("FAIL shift[%0d] op=%h: result=%h cmp=%b expected result=%h cmp=0", i, ops[i], result, cmp, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_compare;
    logic [6:0]  ops [10] = '{OP_LTS, OP_LTU, OP_GES, OP_GEU, OP_EQ, OP_NE, OP_GES, OP_LTU, OP_NE, OP_EQ};
    logic [31:0] av  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1};
    logic [31:0] bv  [10] = '{32'h1, 32'h1, 32'h1, 32'h1,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2};
    logic        exp [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_res;
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], av[i], bv[i]);
      exp_res = {31'b0, exp[i]};
      n_checks++;
      if (cmp !== exp[i] || result !== exp_res)
        $display("FAIL compare[%0d] op=%h: cmp=%b result=%h expected cmp=%b result=%h", i, ops[i], cmp, result, exp[i], exp_res);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    drive(OP_ADD, 32'd1, 32'd1);
    n_checks++;
    if (result !== 32'd2 || cmp !== 1'b0)
      $display("FAIL b2b_add: result=%h cmp=%b expected result=00000002 cmp=0", result, cmp);
    else n_pass++;
    drive(OP_SUB, 32'd1, 32'd1);
    n_checks++;
    if (result !== 32'd0 || cmp !== 1'b0)
      $display("FAIL b2b_sub: result=%h cmp=%b expected result=00000000 cmp=0", result, cmp);
    else n_pass++;
    drive(OP_LTU, 32'd0, 32'd1);
    n_checks++;
    if (result !== 32'd1 || cmp !== 1'b1)
      $display("FAIL b2b_ltu: result=%h cmp=%b expected result=00000001 cmp=1", result, cmp);
    else n_pass++;
  endtask

  task automatic test_unknown_op;
    drive(OP_EQ, 32'd3, 32'd3);
    n_checks++;
    if (cmp !== 1'b1)
      $display("FAIL unk_setup_eq: cmp=%b expected 1", cmp);
    else n_pass++;
    drive(7'h7F, 32'd3, 32'd3);
    n_checks++;
    if (result !== 32'd0 || cmp !== 1'b0)
      $display("FAIL unk_7f: result=%h cmp=%b expected result=00000000 cmp=0", result, cmp);
    else n_pass++;
`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
    n_checks++;
    if (illegal !== 1'b1)
      $display("FAIL illegal_set: illegal_op=%b expected 1", illegal);
    else n_pass++;
`endif
    // ADD encoding with bit 6 set must not alias to ADD.
    drive(7'h58, 32'd2, 32'd3);
    n_checks++;
    if (result !== 32'd0 || cmp !== 1'b0)
      $display("FAIL unk_58: result=%h cmp=%b expected result=00000000 cmp=0", result, cmp);
    else n_pass++;
    drive(OP_ADD, 32'd2, 32'd3);
    n_checks++;
    if (result !== 32'd5)
      $display("FAIL unk_recover_add: result=%h expected 00000005", result);
    else n_pass++;
`ifdef MIRISCV_ALU_ILLEGAL_OP_EN
    n_checks++;
    if (illegal !== 1'b0)
      $display("FAIL illegal_clear: illegal_op=%b expected 0", illegal);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_priority;
    rst = 1'b1;
    drive(OP_NE, 32'd1, 32'd2);
    n_checks++;
    if (result !== 32'd0 || cmp !== 1'b0)
      $display("FAIL reset_priority: result=%h cmp=%b expected result=00000000 cmp=0", result, cmp);
    else n_pass++;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    op  = OP_ADD;
    a   = 32'd0;
    b   = 32'd0;
    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_back_to_back();
    test_unknown_op();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
